onchip_mem_stream_reader: RTL and testbench

- Avalon-MM read master placed directly upstream of the CPU on-chip RAM. It drives the RAM's address, chipselect and clken pins and consumes its unregistered readdata.
- A start pulse defines a word window (base, length). The block reads that window sequentially and presents each word on a valid/ready stream for downstream consumers such as a UART or display.
- A small output buffer absorbs the RAM's fixed 1-cycle read latency. The RAM has no waitrequest, so the block throttles issue internally to handle sink backpressure.

---
 rtl/onchip_mem_pkg.sv | 22 ++
 rtl/stream_skid_fifo.sv | 64 ++++++
 rtl/onchip_mem_stream_reader.sv | 114 +++++++++++
 tb/tb_onchip_mem_stream_reader.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_mem_pkg.sv
// Shared constants, FSM state type and address-wrap helper for the on-chip
// RAM stream reader.
package onchip_mem_pkg;

    localparam int unsigned MEM_ADDR_W = 13;
    localparam int unsigned MEM_DATA_W = 32;
    localparam int unsigned MEM_DEPTH  = 6500;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    // The RAM is not a power of two deep, so the word address wraps explicitly.
    function automatic int unsigned next_addr(input int unsigned addr,
                                              input int unsigned depth = MEM_DEPTH);
        return (addr >= depth - 1) ? 0 : addr + 1;
    endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// Small shift-style FIFO whose head is always entry 0, so the stream
// data/valid come straight from registers.
module stream_skid_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic [DATA_W-1:0]            push_data_i,
    input  logic                         pop_i,
    output logic [DATA_W-1:0]            head_data_o,
    output logic                         head_valid_o,
    output logic [$clog2(DEPTH+1)-1:0]   occ_o
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] buf_q [DEPTH];
    logic [DATA_W-1:0] buf_d [DEPTH];
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [OCC_W-1:0]  wr_idx;
    logic              pop;

    assign pop    = pop_i && (occ_q != '0);
    // A simultaneous pop shifts the queue first, so the push lands one slot lower.
    assign wr_idx = occ_q - OCC_W'(pop);

    always_comb begin
        buf_d = buf_q;
        if (pop) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                buf_d[i] = buf_q[i+1];
            end
            buf_d[DEPTH-1] = '0;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (push_i && (wr_idx == OCC_W'(i))) begin
                buf_d[i] = push_data_i;
            end
        end
        occ_d = occ_q + OCC_W'(push_i) - OCC_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            occ_q <= '0;
        end else begin
            buf_q <= buf_d;
            occ_q <= occ_d;
        end
    end

    assign head_data_o  = buf_q[0];
    assign head_valid_o = (occ_q != '0);
    assign occ_o        = occ_q;

    overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && !pop && (occ_q == OCC_W'(DEPTH))));

endmodule

// File: rtl/onchip_mem_stream_reader.sv
// Avalon-MM read master for the CPU on-chip RAM: reads a word window
// sequentially and presents it on a valid/ready stream.
module onchip_mem_stream_reader
    import onchip_mem_pkg::*;
#(
    parameter int unsigned ADDR_W    = MEM_ADDR_W,
    parameter int unsigned DATA_W    = MEM_DATA_W,
    parameter int unsigned DEPTH     = MEM_DEPTH,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int unsigned OCC_W = $clog2(BUF_DEPTH + 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] remain_q, remain_d;
    logic              inflight_q;
    logic              issue;
    logic              handshake;
    logic [OCC_W-1:0]  occ;

    assign handshake = out_valid & out_ready;
    // No waitrequest on the RAM: only issue when the returning word is sure to fit.
    assign issue = (state_q == RUN) &&
                   ((32'(occ) + 32'(inflight_q)) < (BUF_DEPTH + 32'(handshake)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            inflight_q <= issue;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d   = base_addr;
                    remain_d = word_count;
                    state_d  = (word_count == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (issue) begin
                    addr_d   = ADDR_W'(next_addr(32'(addr_q), DEPTH));
                    remain_d = remain_q - ADDR_W'(1);
                    if (remain_q == ADDR_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!inflight_q && ((occ == '0) || ((occ == OCC_W'(1)) && handshake))) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy           = (state_q == RUN) || (state_q == DRAIN);
        done           = (state_q == DONE);
        mem_chipselect = issue;
        mem_address    = issue ? addr_q : '0;
    end

    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;
    assign mem_clken      = reset_n;

    stream_skid_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (BUF_DEPTH)
    ) u_out_buf (
        .clk          (clk),
        .rst_n        (reset_n),
        .push_i       (inflight_q),
        .push_data_i  (mem_readdata),
        .pop_i        (handshake),
        .head_data_o  (out_data),
        .head_valid_o (out_valid),
        .occ_o        (occ)
    );

endmodule

// File: tb/tb_onchip_mem_stream_reader.sv
// Randomized self-checking bench for onchip_mem_stream_reader against a
// queue-based window model and a registered-read RAM model.
module tb_onchip_mem_stream_reader;

    localparam int unsigned AW    = 13;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 6500;
    localparam int unsigned BD    = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] word_count = '0;
    logic          busy, done;
    logic [AW-1:0] mem_address;
    logic          mem_chipselect, mem_write, mem_clken;
    logic [3:0]    mem_byteenable;
    logic [DW-1:0] mem_readdata = '0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;

    onchip_mem_stream_reader #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .DEPTH     (DEPTH),
        .BUF_DEPTH (BD)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base_addr      (base_addr),
        .word_count     (word_count),
        .busy           (busy),
        .done           (done),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_chipselect && (32'(mem_address) < DEPTH)) mem_readdata <= ram[mem_address];
    end

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int unsigned rmode = 0;
    logic [AW-1:0] exp_addr [$];
    logic [DW-1:0] exp_data [$];
    int          outstanding = 0;
    int          start_cyc = 0;
    int          first_valid_cyc = -1;
    int          done_cyc = -1;
    int          done_cnt = 0;
    bit          busy_live = 1'b0;
    bit          stalled_prev = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: out_ready = 1'b1;
                1: case (cyc % 4)
                       0: out_ready = 1'b1;
                       1: out_ready = 1'b0;
                       2: out_ready = 1'b0;
                       default: out_ready = 1'b1;
                   endcase
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    always @(negedge clk) begin
        chk("mem_clken", {63'd0, mem_clken}, {63'd0, reset_n});
        chk("mem_write", {63'd0, mem_write}, 64'd0);
        chk("mem_byteenable", {60'd0, mem_byteenable}, 64'hF);
        if (reset_n) begin
            if (mem_chipselect) begin
                if (exp_addr.size() == 0) chk("spurious_cs", 64'd1, 64'd0);
                else chk("issue_addr", {51'd0, mem_address}, {51'd0, exp_addr.pop_front()});
                outstanding++;
            end
            if (out_valid && out_ready) begin
                if (exp_data.size() == 0) chk("spurious_word", 64'd1, 64'd0);
                else chk("out_data", {32'd0, out_data}, {32'd0, exp_data.pop_front()});
                outstanding--;
            end
            chk("occ_bound", {63'd0, outstanding <= int'(BD)}, 64'd1);
            if (stalled_prev) begin
                chk("stall_valid", {63'd0, out_valid}, 64'd1);
                chk("stall_data", {32'd0, out_data}, {32'd0, prev_data});
            end
            stalled_prev = out_valid && !out_ready;
            prev_data    = out_data;
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
                chk("busy_at_done", {63'd0, busy}, 64'd0);
                chk("drained_at_done", 64'(exp_data.size()), 64'd0);
                busy_live = 1'b0;
            end else if (busy_live && cyc > start_cyc) begin
                chk("busy_high", {63'd0, busy}, 64'd1);
            end else if (!busy_live) begin
                chk("busy_idle", {63'd0, busy}, 64'd0);
            end
        end
    end

    task automatic do_start(input int unsigned base, input int unsigned cnt);
        @(posedge clk);
        #1;
        start      = 1'b1;
        base_addr  = AW'(base);
        word_count = AW'(cnt);
        for (int unsigned k = 0; k < cnt; k++) begin
            int unsigned a;
            a = (base + k) % DEPTH;
            exp_addr.push_back(AW'(a));
            exp_data.push_back(ram[a]);
        end
        start_cyc       = cyc;
        first_valid_cyc = -1;
        done_cyc        = -1;
        done_cnt        = 0;
        busy_live       = (cnt != 0);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int unsigned budget);
        int unsigned n;
        n = 0;
        while (done_cyc < 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (done_cyc < 0) chk("done_timeout", 64'd0, 64'd1);
        repeat (3) @(posedge clk);
        chk("done_once", 64'(done_cnt), 64'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_done"}, {63'd0, done}, 64'd0);
        chk({tag, "_cs"}, {63'd0, mem_chipselect}, 64'd0);
        chk({tag, "_addr"}, {51'd0, mem_address}, 64'd0);
        chk({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_data"}, {32'd0, out_data}, 64'd0);
    endtask

    initial begin
        int unsigned n;
        for (int unsigned i = 0; i < DEPTH; i++) ram[i] = DW'(i);

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        @(negedge clk);
        reset_n = 1'b1;

        // Basic window with full-rate sink
        rmode = 0;
        do_start(16, 4);
        wait_done(40);
        chk("basic_first_valid_lat", 64'(first_valid_cyc - start_cyc), 64'd3);
        chk("basic_done_lat", 64'(done_cyc - start_cyc), 64'd7);

        // Periodic backpressure
        rmode = 1;
        do_start(0, 8);
        wait_done(200);

        // Address wrap at the end of the RAM
        rmode = 0;
        do_start(6498, 4);
        wait_done(40);

        // Zero-length command
        do_start(100, 0);
        wait_done(10);
        chk("zero_done_lat", 64'(done_cyc - start_cyc), 64'd1);

        // Start during an active transfer must be ignored
        rmode = 2;
        do_start(200, 12);
        repeat (3) @(posedge clk);
        #1;
        start      = 1'b1;
        base_addr  = AW'(3000);
        word_count = AW'(5);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(200);

        // Reset in the middle of a transfer
        rmode = 0;
        do_start(300, 10);
        n = 0;
        while (exp_data.size() > 7 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("reset_word3_reached", 64'(exp_data.size()), 64'd7);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("midrun");
        exp_addr.delete();
        exp_data.delete();
        outstanding  = 0;
        stalled_prev = 1'b0;
        busy_live    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("held");
        chk("no_done_after_reset", 64'(done_cnt), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        do_start(5, 2);
        wait_done(40);

        // Randomized windows over random RAM contents and random sink behaviour
        for (int unsigned i = 0; i < DEPTH; i++) ram[i] = $urandom;
        for (int t = 0; t < 20; t++) begin
            int unsigned b, c;
            b     = $urandom_range(0, DEPTH - 1);
            c     = $urandom_range(1, 40);
            rmode = $urandom_range(0, 2);
            do_start(b, c);
            wait_done(c * 8 + 50);
        end

        // Maximum length wraps the whole RAM
        rmode = 0;
        do_start(6000, 8191);
        wait_done(8300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
